dot_result_drain: RTL and testbench
===================================

Name: dot_result_drain

Overview:
- Reads the per-lane dot-product result vector once accumulation finishes.
- Takes a snapshot of the vector on a start command.
- Streams the selected elements one at a time over a valid/ready write interface to the vector register file or memory port, using consecutive addresses from a base address.
- It is the consumer side of the dot-product result vector and frees the accumulator for the next operation as soon as the snapshot is taken.

Parameters:
- PE_COUNT, 4, number of lanes and elements in the result vector; power of two, ≥2
- DATA_WIDTH, 32, width of each element
- ADDR_WIDTH, 8, width of the write address

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- dot_in  in  [PE_COUNT-1:0][DATA_WIDTH-1:0]  result vector from the dot-product unit
- start  in  1  begin a drain; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  address of element 0; sampled with start
- count  in  $clog2(PE_COUNT+1)  number of elements to drain; sampled with start
- wr_valid  out  1  write beat valid
- wr_ready  in  1  sink accepts beat
- wr_addr  out  ADDR_WIDTH  write address
- wr_data  out  DATA_WIDTH  write data
- wr_last  out  1  marks final beat
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a drain completes

Behaviour:
- Reset is asynchronous and active-low.
  - All of the following are 0 on reset: state (IDLE), snapshot, idx, wr_valid, wr_addr, wr_data, wr_last, busy, done.
  - Reset asserted mid-drain aborts the drain immediately. No done pulse is generated.
- States: IDLE, DRAIN, DONE.
- IDLE, start=1:
  - Snapshot dot_in (all lanes) and base_addr.
  - Set n = min(count, PE_COUNT); counts above PE_COUNT are clamped.
  - Set idx = 0.
  - If n=0, go to DONE with no beats. Otherwise go to DRAIN.
- DRAIN:
  - Outputs are registered.
  - wr_valid=1 from the cycle after start.
  - wr_data = snapshot[idx].
  - wr_addr = base_addr + idx, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH).
  - wr_last = (idx == n-1).
- Handshake:
  - A beat transfers on a cycle where wr_valid & wr_ready.
  - While wr_valid=1 and wr_ready=0, wr_addr, wr_data and wr_last hold stable.
  - wr_valid never drops without a transfer.
  - The next beat is presented in the cycle right after a transfer. With wr_ready held high, the block sustains one beat per cycle with no bubbles.
  - On transfer of the last beat: next cycle wr_valid=0, wr_last=0, state goes to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=1.
  - Next state is IDLE.
- busy=1 from the cycle after start through DONE.
- start while busy is ignored: no re-snapshot and no error.
- start in the same cycle as the DONE→IDLE transition is also ignored. start is only accepted when state is IDLE.
- Changes on dot_in after the snapshot do not affect the drain in progress.
- Latency: start at cycle T → first beat valid at T+1 → done at T+1+n+(total wr_ready-low stall cycles).
  - For n=0: done at T+1.
- No arithmetic on the data path; wr_data is a pure element copy.

Test Plan:
- Reset, then PE_COUNT=4, dot_in={40,30,20,10} (lane3..lane0), base_addr=0x10, count=4, wr_ready=1 → four beats on consecutive cycles T+1..T+4: (0x10,10), (0x11,20), (0x12,30), (0x13,40,last). done at T+5, then busy=0.
- Same vector, wr_ready low for 3 cycles at beat 1 → beat (0x11,20) holds stable with wr_valid=1 while stalled; data order unchanged; done at T+8.
- base_addr=0xFE, count=4 → addresses 0xFE, 0xFF, 0x00, 0x01; wr_last only on 0x01.
- count=0 → no wr_valid at all; done pulses at T+1. count=7 → clamped: exactly 4 beats.
- start pulsed again during DRAIN, and dot_in changed to all 0xFFFFFFFF after the snapshot → the original values are drained and the second start is ignored.
- rstn asserted for 1 cycle mid-drain after beat 1 → wr_valid, busy and done go to 0 immediately; a subsequent start with count=2 drains 2 beats correctly from idx 0.

Source files
------------

// File: rtl/dot_result_drain_if.sv
// dot_result_drain_if: valid/ready write bus from the result drain to the register file or memory port.
//   wr_valid : beat valid (master -> slave)
//   wr_ready : sink accepts beat (slave -> master)
//   wr_addr  : write address
//   wr_data  : write data
//   wr_last  : final beat of the drain
interface dot_result_drain_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_last;
    modport master (output wr_valid, wr_addr, wr_data, wr_last, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_data, wr_last, output wr_ready);
endinterface

// File: rtl/dot_result_drain.sv
// dot_result_drain: snapshots the dot-product result vector on start and streams n elements to consecutive addresses.
//   clk, rstn : clock, asynchronous active-low reset
//   dot_in    : per-lane result vector
//   start     : begin a drain (accepted only in IDLE)
//   base_addr : address of element 0, sampled with start
//   count     : elements to drain, clamped to PE_COUNT, sampled with start
//   wr        : valid/ready write bus (master side)
//   busy      : high outside IDLE
//   done      : one-cycle pulse when a drain completes
module dot_result_drain #(
    parameter  int PE_COUNT   = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 8,
    localparam int CW         = $clog2(PE_COUNT + 1),
    localparam int IW         = $clog2(PE_COUNT)
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [PE_COUNT-1:0][DATA_WIDTH-1:0] dot_in,
    input  logic                                start,
    input  logic [ADDR_WIDTH-1:0]               base_addr,
    input  logic [CW-1:0]                       count,
    dot_result_drain_if.master                  wr,
    output logic                                busy,
    output logic                                done
);
    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;
    state_t                              state, state_nxt;
    logic [PE_COUNT-1:0][DATA_WIDTH-1:0] snap;
    logic [ADDR_WIDTH-1:0]               base_q, addr_q;
    logic [DATA_WIDTH-1:0]               data_q;
    logic [CW-1:0]                       n_q, n_in;
    logic [IW-1:0]                       idx, idx_n;
    logic                                valid_q, last_q, accept, xfer;
    always_comb begin
        accept    = (state == IDLE) && start;
        xfer      = valid_q && wr.wr_ready;
        n_in      = (count > CW'(PE_COUNT)) ? CW'(PE_COUNT) : count;
        idx_n     = idx + IW'(1);
        state_nxt = (state == IDLE)  ? (!start ? IDLE : (n_in == '0) ? DONE : DRAIN) :
                    (state == DRAIN) ? ((xfer && last_q) ? DONE : DRAIN) : IDLE;
    end
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    // Outputs are registered; the next beat is preloaded on the transfer edge so ready-high gives one beat per cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            snap    <= '0;
            base_q  <= '0;
            n_q     <= '0;
            idx     <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (accept) begin
            snap    <= dot_in;
            base_q  <= base_addr;
            n_q     <= n_in;
            idx     <= '0;
            valid_q <= n_in != '0;
            addr_q  <= base_addr;
            data_q  <= dot_in[0];
            last_q  <= n_in == CW'(1);
        end else if (xfer && last_q) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (xfer) begin
            idx     <= idx_n;
            addr_q  <= base_q + ADDR_WIDTH'(idx_n);
            data_q  <= snap[idx_n];
            last_q  <= (CW'(idx_n) + CW'(1)) == n_q;
        end
    end
    assign wr.wr_valid = valid_q;
    assign wr.wr_addr  = addr_q;
    assign wr.wr_data  = data_q;
    assign wr.wr_last  = last_q;
    assign busy        = state != IDLE;
    assign done        = state == DONE;
endmodule

// File: tb/tb_dot_result_drain.sv
// tb_dot_result_drain: table-driven, hand-written and randomized checks of dot_result_drain against a queue model.
module tb_dot_result_drain;
    localparam int PE = 4;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int CW = 3;
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
    } beat_t;
    typedef struct {
        logic [PE-1:0][DW-1:0] vec;
        logic [AW-1:0]         base;
        logic [CW-1:0]         cnt;
        int                    stall_at;
        int                    stall_len;
        bit                    restart;
        int                    lat;
    } vec_t;
    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  start = 1'b0;
    logic [PE-1:0][DW-1:0] dot_in = '0;
    logic [AW-1:0]         base_addr = '0;
    logic [CW-1:0]         count = '0;
    logic                  busy, done;
    int                    checks = 0;
    int                    failures = 0;
    dot_result_drain_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    dot_result_drain #(.PE_COUNT(PE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rstn(rstn), .dot_in(dot_in), .start(start), .base_addr(base_addr),
        .count(count), .wr(bus), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask
    task automatic chk_idle(input string name);
        chk({name, "_valid"}, 64'(bus.wr_valid), 0);
        chk({name, "_busy"}, 64'(busy), 0);
        chk({name, "_done"}, 64'(done), 0);
    endtask
    // Model: the expected beat list is fixed at start from the vector, base and clamped count.
    task automatic run_drain(input logic [PE-1:0][DW-1:0] vec, input logic [AW-1:0] base, input logic [CW-1:0] cnt,
                             input int stall_at, input int stall_len, input bit restart, input bit rnd, input int lat);
        beat_t q[$];
        beat_t b;
        int    n, cyc, sent, stalls;
        bit    fin;
        n = (int'(cnt) > PE) ? PE : int'(cnt);
        for (int i = 0; i < n; i++) begin
            b.a = base + AW'(i);
            b.d = vec[i];
            b.l = (i == n - 1);
            q.push_back(b);
        end
        @(negedge clk);
        dot_in = vec; base_addr = base; count = cnt; start = 1'b1; bus.wr_ready = 1'b1;
        cyc = 0; sent = 0; stalls = 0; fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            start = restart && cyc == 2;
            if (restart && cyc == 2) dot_in = '1;
            bus.wr_ready = rnd ? ($urandom_range(0, 2) != 0) : !(sent == stall_at && stalls < stall_len);
            if (cyc > 40) begin
                checks++; failures++;
                $display("FAIL timeout waiting for done actual=%0d cycles required<=40", cyc);
                fin = 1'b1;
            end else if (bus.wr_valid) begin
                chk("busy_drain", 64'(busy), 1);
                if (q.size() == 0) chk("extra_beat", 1, 0);
                else begin
                    chk("wr_addr", 64'(bus.wr_addr), 64'(q[0].a));
                    chk("wr_data", 64'(bus.wr_data), 64'(q[0].d));
                    chk("wr_last", 64'(bus.wr_last), 64'(q[0].l));
                    if (bus.wr_ready) begin
                        void'(q.pop_front());
                        sent++;
                    end else stalls++;
                end
            end else if (done) begin
                chk("done_lat", 64'(cyc), 64'((lat < 0) ? 1 + n + stalls : lat));
                chk("beats_left", 64'(q.size()), 0);
                chk("busy_done", 64'(busy), 1);
                chk("last_done", 64'(bus.wr_last), 0);
                start = restart;
                fin = 1'b1;
            end
        end
        bus.wr_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_idle("after_done");
        @(negedge clk);
        chk_idle("stay_idle");
    endtask
    initial begin
        vec_t tbl[7];
        logic [PE-1:0][DW-1:0] v0, v1, rv;
        v0 = {32'd40, 32'd30, 32'd20, 32'd10};
        v1 = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};
        tbl[0] = '{v0, 8'h10, 3'd4, -1, 0, 1'b0, 5};
        tbl[1] = '{v0, 8'h10, 3'd4, 1, 3, 1'b0, 8};
        tbl[2] = '{v0, 8'hFE, 3'd4, -1, 0, 1'b0, 5};
        tbl[3] = '{v0, 8'h20, 3'd0, -1, 0, 1'b0, 1};
        tbl[4] = '{v1, 8'h30, 3'd7, -1, 0, 1'b0, 5};
        tbl[5] = '{v1, 8'hFF, 3'd1, 0, 2, 1'b0, 4};
        tbl[6] = '{v0, 8'h50, 3'd3, -1, 0, 1'b1, 4};
        bus.wr_ready = 1'b1;
        #1;
        chk_idle("reset");
        chk("reset_addr", 64'(bus.wr_addr), 0);
        chk("reset_data", 64'(bus.wr_data), 0);
        chk("reset_last", 64'(bus.wr_last), 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 7; i++)
            run_drain(tbl[i].vec, tbl[i].base, tbl[i].cnt, tbl[i].stall_at, tbl[i].stall_len, tbl[i].restart, 1'b0, tbl[i].lat);
        @(negedge clk);
        dot_in = v1; base_addr = 8'h40; count = 3'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_addr", 64'(bus.wr_addr), 64'h42);
        rstn = 1'b0;
        #1;
        chk_idle("mid_reset");
        chk("mid_reset_addr", 64'(bus.wr_addr), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk_idle("post_reset");
        run_drain({32'h4, 32'h3, 32'h2, 32'h1}, 8'h80, 3'd2, -1, 0, 1'b0, 1'b0, 3);
        for (int k = 0; k < 25; k++) begin
            rv = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_drain(rv, AW'($urandom()), CW'($urandom_range(0, 7)), -1, 0, 1'b0, 1'b1, -1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
